// File: rtl/unit_output_drain_pkg.sv
// Shared definitions for the per-unit output drain: word layout, store
// geometry, global mode encoding and the drain FSM state type.
package unit_output_drain_pkg;

  // Stored word layout, MSB first: {row_idx, value, valid}
  localparam int BITS_ROW_IDX       = 8;
  localparam int DATA_PRECISION     = 16;
  localparam int DATA_WIDTH_ADD_STG = BITS_ROW_IDX + DATA_PRECISION + 1;

  // Store geometry; at most NUM_OUTPUT_WORDS_PER_UNIT-1 words are ever valid
  localparam int NUM_OUTPUT_WORDS_PER_UNIT = 16;
  localparam int BITS_OUTPUT_ADDR_PER_UNIT = $clog2(NUM_OUTPUT_WORDS_PER_UNIT);

  // Global mode encoding: merge pass active
  localparam logic MODE_WORK = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FINISH
  } drain_state_t;

endpackage

// File: rtl/unit_output_drain_beat.sv
// Single-entry valid/ready holding register for one readout beat.
// Extracts the row index and value fields from a raw store word; the
// word's low valid flag is dropped because the store only holds valid words.
module out_beat_reg
  import unit_output_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_ADD_STG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      ready,
  input  logic [DATA_WIDTH-1:0]     data,
  output logic                      valid,
  output logic [BITS_ROW_IDX-1:0]   row_idx,
  output logic [DATA_PRECISION-1:0] value
);

  localparam int LOW_BITS = DATA_WIDTH - BITS_ROW_IDX - DATA_PRECISION;

  logic unused_low_bits;
  assign unused_low_bits = ^data[LOW_BITS-1:0];

  // Load a new beat, or empty the register once the consumer takes it; hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      row_idx <= '0;
      value   <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      row_idx <= data[DATA_WIDTH-1 -: BITS_ROW_IDX];
      value   <= data[DATA_WIDTH-BITS_ROW_IDX-1 -: DATA_PRECISION];
    end else if (valid && ready) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/unit_output_drain.sv
// Reads back every word captured by the per-unit output store, in write
// order, and streams each one as a {row_idx, value} beat toward the host.
// The store fill count is latched at start; done pulses once the final
// beat has been taken by the consumer.
module unit_output_drain
  import unit_output_drain_pkg::*;
#(
  parameter int DATA_WIDTH                = DATA_WIDTH_ADD_STG,
  parameter int NUM_OUTPUT_WORDS_PER_UNIT = unit_output_drain_pkg::NUM_OUTPUT_WORDS_PER_UNIT,
  parameter int BITS_OUTPUT_ADDR_PER_UNIT = $clog2(NUM_OUTPUT_WORDS_PER_UNIT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 mode,
  input  logic                                 start,
  input  logic [BITS_OUTPUT_ADDR_PER_UNIT-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]                rd_data,
  output logic [BITS_OUTPUT_ADDR_PER_UNIT-1:0] rd_addr,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [BITS_ROW_IDX-1:0]              out_row_idx,
  output logic [DATA_PRECISION-1:0]            out_value,
  output logic                                 busy,
  output logic                                 done
);

  drain_state_t                         state;
  logic [BITS_OUTPUT_ADDR_PER_UNIT-1:0] count;
  logic [BITS_OUTPUT_ADDR_PER_UNIT-1:0] issued;
  logic                                 slot_free;
  logic                                 load;
  logic                                 drained;

  // The holding register can take a word when empty or when its beat leaves this cycle
  assign slot_free = !out_valid || out_ready;
  assign load      = (state == DRAIN) && (issued != count) && slot_free;
  assign drained   = (state == DRAIN) && (issued == count) && slot_free;
  assign busy      = (state != IDLE);

  out_beat_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_beat (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .ready   (out_ready),
    .data    (rd_data),
    .valid   (out_valid),
    .row_idx (out_row_idx),
    .value   (out_value)
  );

  // Drain sequencer: latch the fill count, walk the read address, pulse done in FINISH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_addr <= '0;
      count   <= '0;
      issued  <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && (mode != MODE_WORK)) begin
            count   <= wr_addr;
            issued  <= '0;
            rd_addr <= '0;
            if (wr_addr == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (load) begin
            rd_addr <= rd_addr + 1'b1;
            issued  <= issued + 1'b1;
          end
          if (drained) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          done    <= 1'b0;
          rd_addr <= '0;
          state   <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
